network_access_controller: RTL and testbench

Requester-side controller for one mesh access port (North, South, East or West). It accepts read/write requests from a client over a valid/ready interface and buffers them in an in-order queue. It drives the port's address/read/write/data inputs to the network, waits for `readReady`, and returns read data, or a timeout error, over a valid/ready response interface. One instance sits between each client and each network access port.

---
 rtl/network_access_controller.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_network_access_controller.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/network_access_controller.sv
// Requester-side controller for one mesh access port: queues client reads/writes, issues them to the network in order, and returns read data or a timeout error.
// Latency: accept -> IDLE pop +1, read/write strobe +2; response one cycle after readReady is sampled in WAIT.
// Backpressure: req_ready drops when the queue is full; a pending response holds stable until resp_ready.
//
// Ports:
//   clk, reset                  sole clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready         client request handshake; req_write, req_addr, req_data payload
//   resp_valid/resp_ready       read response handshake; resp_data, resp_error payload
//   destinationAddressOut, readOut, writeOut, dataOut   drive the network access port
//   readReady, dataIn           read completion from the network access port
//
// Optional feature macro: ACCESS_PORT_TIMEOUT_EN (timeout counter and error response).
// Widths normally come from globalVariables.v; defaults below apply when it is not included.

`ifndef NETWORK_ADDRESS_WIDTH
`define NETWORK_ADDRESS_WIDTH 4
`endif
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

`define NAC_AW (`NETWORK_ADDRESS_WIDTH + `CACHE_BANK_ADDRESS_WIDTH)
`define NAC_DW (`DATA_WIDTH)

// Generic synchronous FIFO with combinational head read.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: pushes are dropped while full, pops ignored while empty; full ignores a same-cycle pop.
module nac_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_push    = i_push && !o_full;
    assign w_pop     = i_pop && !o_empty;
    assign o_pop_dat = r_mem[r_rd_ptr];

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end
endmodule

module network_access_controller #(
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [`NAC_AW-1:0] req_addr,
    input  logic [`NAC_DW-1:0] req_data,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [`NAC_DW-1:0] resp_data,
    output logic               resp_error,
    output logic [`NAC_AW-1:0] destinationAddressOut,
    output logic               readOut,
    output logic               writeOut,
    output logic [`NAC_DW-1:0] dataOut,
    input  logic               readReady,
    input  logic [`NAC_DW-1:0] dataIn
);
    localparam int AW = `NAC_AW;
    localparam int DW = `NAC_DW;

    // Elaboration-time parameter legality checks.
    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("QUEUE_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    req_t          w_push_dat;
    req_t          w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_addr_nxt;
    logic [DW-1:0] r_data;
    logic [DW-1:0] w_data_nxt;
    logic          r_wflag;
    logic          w_wflag_nxt;
    logic          r_rd;
    logic          w_rd_nxt;
    logic          r_wr;
    logic          w_wr_nxt;
    logic          r_resp_vld;
    logic          w_resp_vld_nxt;
    logic [DW-1:0] r_resp_dat;
    logic [DW-1:0] w_resp_dat_nxt;
`ifdef ACCESS_PORT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_resp_err;
    logic          w_resp_err_nxt;
`endif

    assign w_push_dat = '{write: req_write, addr: req_addr, data: req_data};
    assign req_ready  = !w_full;

    nac_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_req_q (
        .clk        (clk),
        .rst_n      (reset),
        .i_push     (req_valid),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_wflag_nxt    = r_wflag;
        w_rd_nxt       = 1'b0;
        w_wr_nxt       = 1'b0;
        w_resp_vld_nxt = r_resp_vld;
        w_resp_dat_nxt = r_resp_dat;
`ifdef ACCESS_PORT_TIMEOUT_EN
        w_cnt_nxt      = r_cnt;
        w_resp_err_nxt = r_resp_err;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_addr_nxt  = w_head.addr;
                    w_data_nxt  = w_head.data;
                    w_wflag_nxt = w_head.write;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Strobe registers are set here so they are high for exactly the following cycle.
                w_rd_nxt = !r_wflag;
                w_wr_nxt = r_wflag;
                if (r_wflag) begin
                    w_state_nxt = ST_IDLE;
                end else begin
`ifdef ACCESS_PORT_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Data takes priority over a coincident timeout.
                if (readReady) begin
                    w_resp_dat_nxt = dataIn;
                    w_resp_vld_nxt = 1'b1;
`ifdef ACCESS_PORT_TIMEOUT_EN
                    w_resp_err_nxt = 1'b0;
`endif
                    w_state_nxt    = ST_RESP;
                end
`ifdef ACCESS_PORT_TIMEOUT_EN
                else if (r_cnt == CNT_LAST) begin
                    w_resp_dat_nxt = '0;
                    w_resp_err_nxt = 1'b1;
                    w_resp_vld_nxt = 1'b1;
                    w_state_nxt    = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_resp_vld_nxt = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr     <= '0;
            r_data     <= '0;
            r_wflag    <= 1'b0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_resp_vld <= 1'b0;
            r_resp_dat <= '0;
`ifdef ACCESS_PORT_TIMEOUT_EN
            r_cnt      <= '0;
            r_resp_err <= 1'b0;
`endif
        end else begin
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_wflag    <= w_wflag_nxt;
            r_rd       <= w_rd_nxt;
            r_wr       <= w_wr_nxt;
            r_resp_vld <= w_resp_vld_nxt;
            r_resp_dat <= w_resp_dat_nxt;
`ifdef ACCESS_PORT_TIMEOUT_EN
            r_cnt      <= w_cnt_nxt;
            r_resp_err <= w_resp_err_nxt;
`endif
        end
    end

    assign destinationAddressOut = r_addr;
    assign dataOut               = r_data;
    assign readOut               = r_rd;
    assign writeOut              = r_wr;
    assign resp_valid            = r_resp_vld;
    assign resp_data             = r_resp_dat;
`ifdef ACCESS_PORT_TIMEOUT_EN
    assign resp_error            = r_resp_err;
`else
    assign resp_error            = 1'b0;
`endif
endmodule

// File: tb/tb_network_access_controller.sv
// Bench for network_access_controller: vector table plus corner-case sequences,
// with issue/response scoreboards checked by a negedge monitor and a simple network model.
`timescale 1ns/1ps

`ifndef NETWORK_ADDRESS_WIDTH
`define NETWORK_ADDRESS_WIDTH 4
`endif
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_network_access_controller;
    localparam int AW = `NETWORK_ADDRESS_WIDTH + `CACHE_BANK_ADDRESS_WIDTH;
    localparam int DW = `DATA_WIDTH;
    localparam int TO = 64;

    logic          clk;
    logic          reset;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          resp_valid, resp_ready, resp_error;
    logic [DW-1:0] resp_data;
    logic [AW-1:0] destinationAddressOut;
    logic          readOut, writeOut;
    logic [DW-1:0] dataOut;
    logic          readReady;
    logic [DW-1:0] dataIn;

    logic          net_rr, man_rr;
    logic [DW-1:0] net_di, man_di;
    assign readReady = net_rr | man_rr;
    assign dataIn    = man_rr ? man_di : net_di;

    network_access_controller #(.QUEUE_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_error(resp_error),
        .destinationAddressOut(destinationAddressOut), .readOut(readOut),
        .writeOut(writeOut), .dataOut(dataOut),
        .readReady(readReady), .dataIn(dataIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string nm, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", nm, what, cyc);
    endtask

    typedef struct { bit w; logic [AW-1:0] a; logic [DW-1:0] d; } issue_t;
    typedef struct { logic [DW-1:0] d; logic e; } resp_t;
    issue_t q_issue[$];
    resp_t  q_resp[$];

    // Network model: backing memory, writes update it, reads answer after net_lat cycles.
    logic [DW-1:0] mem [1<<AW];
    bit net_auto = 1'b1;
    int net_lat  = 1;
    bit net_act;
    int net_cnt;

    initial begin
        net_rr = 1'b0; net_di = '0; net_act = 1'b0; net_cnt = 0;
        forever begin
            @(negedge clk);
            net_rr = 1'b0;
            if (!reset) begin
                net_act = 1'b0;
            end else begin
                if (writeOut) mem[destinationAddressOut] = dataOut;
                if (net_act) begin
                    if (net_cnt == 0) begin
                        net_rr  = 1'b1;
                        net_di  = mem[destinationAddressOut];
                        net_act = 1'b0;
                    end else begin
                        net_cnt--;
                    end
                end
                if (readOut && net_auto) begin
                    net_act = 1'b1;
                    net_cnt = net_lat - 1;
                end
            end
        end
    end

    // Monitor: issue order/pulse shape and response payload/stability.
    int last_wr_cyc = 0;
    int last_rd_cyc = 0;
    initial begin
        bit prev_issue;
        bit hold;
        logic [DW-1:0] held_d;
        logic held_e;
        issue_t ei;
        resp_t  er;
        prev_issue = 1'b0; hold = 1'b0; held_d = '0; held_e = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_issue = 1'b0;
                hold = 1'b0;
            end else begin
                if (readOut || writeOut) begin
                    chk("issue_one_hot", {31'd0, readOut & writeOut}, 0);
                    chk("issue_single_cycle", {31'd0, prev_issue}, 0);
                    if (q_issue.size() == 0) begin
                        flag_fail("unexpected_issue", "strobe with no queued request");
                    end else begin
                        ei = q_issue.pop_front();
                        chk("issue_kind", {31'd0, writeOut}, {31'd0, ei.w});
                        chk("issue_addr", 32'(destinationAddressOut), 32'(ei.a));
                        if (ei.w) chk("issue_data", 32'(dataOut), 32'(ei.d));
                    end
                    if (writeOut) last_wr_cyc = cyc;
                    if (readOut)  last_rd_cyc = cyc;
                end
                prev_issue = readOut | writeOut;
                if (resp_valid) begin
                    if (hold) begin
                        chk("resp_stable_data", 32'(resp_data), 32'(held_d));
                        chk("resp_stable_err", {31'd0, resp_error}, {31'd0, held_e});
                    end
                    if (resp_ready) begin
                        hold = 1'b0;
                        if (q_resp.size() == 0) begin
                            flag_fail("unexpected_resp", "response with no outstanding read");
                        end else begin
                            er = q_resp.pop_front();
                            chk("resp_data", 32'(resp_data), 32'(er.d));
                            chk("resp_error", {31'd0, resp_error}, {31'd0, er.e});
                        end
                    end else begin
                        hold = 1'b1;
                        held_d = resp_data;
                        held_e = resp_error;
                    end
                end else begin
                    if (hold) flag_fail("resp_dropped", "resp_valid fell without handshake");
                    hold = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int acc_cyc = 0;

    // Drive one request until accepted; push scoreboard expectations on acceptance.
    task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp_d, input logic exp_e);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk); #1;
            if (ok) break;
        end
        req_valid = 1'b0;
        if (!ok) begin
            flag_fail("send_accept", "request never accepted");
        end else begin
            acc_cyc = cyc;
            q_issue.push_back('{w, a, d});
            if (!w) q_resp.push_back('{exp_d, exp_e});
        end
    endtask

    task automatic wait_drain(input string nm, input int limit);
        int t;
        t = 0;
        while ((q_issue.size() != 0 || q_resp.size() != 0) && t < limit) begin
            tick(1); t++;
        end
        if (q_issue.size() != 0 || q_resp.size() != 0) flag_fail(nm, "scoreboard not drained in time");
    endtask

    task automatic wait_resp_valid(output int c);
        int t;
        t = 0;
        while (!resp_valid && t < 200) begin tick(1); t++; end
        if (!resp_valid) flag_fail("resp_wait", "resp_valid never rose");
        c = cyc;
    endtask

    task automatic wait_read_out(output int c);
        int t;
        t = 0;
        while (!readOut && t < 50) begin tick(1); t++; end
        if (!readOut) flag_fail("readout_wait", "readOut never rose");
        c = cyc;
    endtask

    task automatic pulse_rr(input logic [DW-1:0] d);
        man_di = d; man_rr = 1'b1;
        tick(1);
        man_rr = 1'b0;
    endtask

    typedef struct { bit w; logic [AW-1:0] a; logic [DW-1:0] d; int lat; logic [DW-1:0] exp_d; } vec_t;
    vec_t tbl[10];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c0, c1, n;
        bit acc5;
        tbl[0] = '{1'b1, 8'h10, 8'h11, 0, 8'h00};
        tbl[1] = '{1'b1, 8'h11, 8'h22, 0, 8'h00};
        tbl[2] = '{1'b0, 8'h10, 8'h00, 1, 8'h11};
        tbl[3] = '{1'b0, 8'h11, 8'h00, 2, 8'h22};
        tbl[4] = '{1'b1, 8'h10, 8'h99, 0, 8'h00};
        tbl[5] = '{1'b0, 8'h10, 8'h00, 4, 8'h99};
        tbl[6] = '{1'b0, 8'h33, 8'h00, 1, 8'h5C};
        tbl[7] = '{1'b1, 8'hFF, 8'hFF, 0, 8'h00};
        tbl[8] = '{1'b0, 8'hFF, 8'h00, 2, 8'hFF};
        tbl[9] = '{1'b0, 8'h00, 8'h00, 3, 8'h01};
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        mem[8'h33] = 8'h5C;
        mem[8'h00] = 8'h01;
        mem[8'h05] = 8'hA5;
        for (int i = 0; i < 6; i++) mem[8'h20 + i] = DW'(8'h80 + i);

        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
        resp_ready = 1'b1; man_rr = 1'b0; man_di = '0;
        tick(2);
        chk("rst_req_ready", {31'd0, req_ready}, 1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 0);
        chk("rst_resp_error", {31'd0, resp_error}, 0);
        chk("rst_read_write", {30'd0, readOut, writeOut}, 0);
        chk("rst_resp_data", 32'(resp_data), 0);
        chk("rst_addr_out", 32'(destinationAddressOut), 0);
        chk("rst_data_out", 32'(dataOut), 0);
        reset = 1'b1;
        tick(2);

        // Vector table: writes go back-to-back, each read waits for its response.
        for (int i = 0; i < 10; i++) begin
            if (!tbl[i].w) net_lat = tbl[i].lat;
            send(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp_d, 1'b0);
            if (!tbl[i].w) wait_drain("table_read", 100);
        end
        wait_drain("table_end", 100);

        // Single read with stalled client.
        net_lat = 3; resp_ready = 1'b0;
        send(1'b0, 8'h05, 8'h00, 8'hA5, 1'b0);
        c0 = acc_cyc;
        wait_resp_valid(c1);
        chk("read_latency", 32'(c1 - c0), 6);
        chk("single_read_data", 32'(resp_data), 32'h A5);
        chk("single_read_err", {31'd0, resp_error}, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("resp_hold_valid", {31'd0, resp_valid}, 1);
        end
        resp_ready = 1'b1;
        tick(1);
        chk("resp_drop_after_hs", {31'd0, resp_valid}, 0);
        wait_drain("single_read", 50);

        // Write then read, checking strobe timing.
        net_lat = 2;
        send(1'b1, 8'h12, 8'h3C, 8'h00, 1'b0);
        c0 = acc_cyc;
        send(1'b0, 8'h12, 8'h00, 8'h3C, 1'b0);
        wait_drain("write_read", 100);
        chk("write_issue_latency", 32'(last_wr_cyc - c0), 2);
        chk("write_to_read_gap", 32'(last_rd_cyc - last_wr_cyc), 2);

        // Queue full: hold the first read in WAIT, fill the queue, fifth push must stall.
        net_auto = 1'b0; net_lat = 1;
        send(1'b0, 8'h20, 8'h00, 8'h80, 1'b0);
        tick(3);
        for (int i = 1; i < 5; i++) send(1'b0, AW'(8'h20 + i), 8'h00, DW'(8'h80 + i), 1'b0);
        chk("full_after_4th", {31'd0, req_ready}, 0);
        acc5 = 1'b0;
        fork
            begin send(1'b0, 8'h25, 8'h00, 8'h85, 1'b0); acc5 = 1'b1; end
        join_none
        tick(5);
        chk("fifth_blocked", {31'd0, acc5}, 0);
        chk("still_full", {31'd0, req_ready}, 0);
        net_auto = 1'b1;
        pulse_rr(8'h80);
        n = 0;
        while (!acc5 && n < 50) begin tick(1); n++; end
        chk("fifth_accepted", {31'd0, acc5}, 1);
        wait_drain("queue_full", 200);

`ifdef ACCESS_PORT_TIMEOUT_EN
        // Timeout, then readReady on the last WAIT cycle.
        net_auto = 1'b0;
        send(1'b0, 8'h40, 8'h00, 8'h00, 1'b1);
        wait_read_out(c0);
        wait_resp_valid(c1);
        chk("timeout_wait_cycles", 32'(c1 - c0), TO);
        wait_drain("timeout", 20);
        send(1'b0, 8'h41, 8'h00, 8'h77, 1'b0);
        wait_read_out(c0);
        tick(TO - 1);
        pulse_rr(8'h77);
        wait_resp_valid(c1);
        chk("late_data_cycles", 32'(c1 - c0), TO);
        wait_drain("timeout_edge", 20);
        net_auto = 1'b1;
`endif

        // Reset in WAIT with two entries queued.
        net_auto = 1'b0;
        send(1'b0, 8'h50, 8'hC3, 8'h00, 1'b0);
        tick(3);
        send(1'b0, 8'h51, 8'hC4, 8'h00, 1'b0);
        send(1'b0, 8'h52, 8'hC5, 8'h00, 1'b0);
        chk("pre_reset_addr", 32'(destinationAddressOut), 32'h50);
        #2 reset = 1'b0;
        #1;
        chk("arst_req_ready", {31'd0, req_ready}, 1);
        chk("arst_strobes", {30'd0, readOut, writeOut}, 0);
        chk("arst_resp", {30'd0, resp_valid, resp_error}, 0);
        chk("arst_resp_data", 32'(resp_data), 0);
        chk("arst_addr_out", 32'(destinationAddressOut), 0);
        chk("arst_data_out", 32'(dataOut), 0);
        q_issue.delete();
        q_resp.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        tick(1);
        pulse_rr(8'h5A);
        n = 0;
        for (int i = 0; i < 10; i++) begin tick(1); if (resp_valid) n++; end
        chk("no_resp_after_reset", 32'(n), 0);
        net_auto = 1'b1;

        // Stray readReady while idle.
        pulse_rr(8'h66);
        n = 0;
        for (int i = 0; i < 6; i++) begin tick(1); if (resp_valid) n++; end
        chk("stray_readready", 32'(n), 0);

        tick(3);
        chk("sb_issue_empty", 32'(q_issue.size()), 0);
        chk("sb_resp_empty", 32'(q_resp.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
